// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control unit
//
// Contents: FSM state encoding, opcode/funct constants, ALUOp codes and the
// packed instruction-class record produced by mc_ctrl_decode.
// Optional feature macro: MEM_TIMEOUT_EN (adds the TOUT state).
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
`ifdef MEM_TIMEOUT_EN
        ,
        ST_TOUT   = 3'd5
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [2:0] OP_ITYPE_HI = 3'b001;

    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;

    typedef struct packed {
        logic is_r;
        logic is_i;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic jr;
        logic sftmd;
    } ctrl_class_t;

    function automatic logic is_shift_funct(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA) ||
               (fn == FN_SLLV) || (fn == FN_SRLV) || (fn == FN_SRAV);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational instruction-class decode
//
// Ports:
//   i_opcode  in  6  instruction[31:26]
//   i_funct   in  6  instruction[5:0]
//   o_cls     out    class flags (R/I/lw/sw/beq/bne/j/jal/jr/shift)
//   o_legal   out 1  opcode is one the controller can sequence
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    output ctrl_class_t o_cls,
    output logic        o_legal
);

    logic w_is_r;

    assign w_is_r = (i_opcode == OP_RTYPE);

    always_comb begin
        o_cls       = '0;
        o_cls.is_r  = w_is_r;
        o_cls.is_i  = (i_opcode[5:3] == OP_ITYPE_HI);
        o_cls.lw    = (i_opcode == OP_LW);
        o_cls.sw    = (i_opcode == OP_SW);
        o_cls.beq   = (i_opcode == OP_BEQ);
        o_cls.bne   = (i_opcode == OP_BNE);
        o_cls.j     = (i_opcode == OP_J);
        o_cls.jal   = (i_opcode == OP_JAL);
        o_cls.jr    = w_is_r && (i_funct == FN_JR);
        o_cls.sftmd = w_is_r && is_shift_funct(i_funct);
    end

    assign o_legal = w_is_r | (i_opcode[5:3] == OP_ITYPE_HI) |
                     (i_opcode == OP_LW)  | (i_opcode == OP_SW)  |
                     (i_opcode == OP_BEQ) | (i_opcode == OP_BNE) |
                     (i_opcode == OP_J)   | (i_opcode == OP_JAL);

endmodule

// File: rtl/mc_control32.sv
// rtl/mc_control32.sv - multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB)
//
// Optional feature macro: MEM_TIMEOUT_EN (MEM wait limit + TOUT state).
// Ports:
//   clock, reset                 clock (rising) and synchronous active-high reset
//   Opcode, Function_opcode      instruction fields from IR
//   Alu_resultHigh               ALU result high bits, sampled in EXEC for lw/sw
//   mem_ready                    dmem/IO access completes this cycle (MEM only)
//   IRWrite, PCWrite             IR load and PC commit strobes
//   Jr, Jmp, Jal, Branch, nBranch   instruction-class qualifiers
//   RegDST, ALUSrc, I_format, Sftmd, ALUOp   datapath selects, DECODE..WB
//   RegWrite, MemorIOtoReg       register-file write strobe and WB source
//   MemRead, MemWrite, IORead, IOWrite      access strobes, MEM only
//   illegal                      pulse on unsupported opcode (or MEM timeout)
//   state_o                      current state
module mc_control32
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_HIGH_W    = 22,
    parameter logic [ADDR_HIGH_W-1:0] IO_BASE_HIGH = {ADDR_HIGH_W{1'b1}},
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             Opcode,
    input  logic [5:0]             Function_opcode,
    input  logic [ADDR_HIGH_W-1:0] Alu_resultHigh,
    input  logic                   mem_ready,
    output logic                   IRWrite,
    output logic                   PCWrite,
    output logic                   Jr,
    output logic                   Jmp,
    output logic                   Jal,
    output logic                   Branch,
    output logic                   nBranch,
    output logic                   RegDST,
    output logic                   ALUSrc,
    output logic                   I_format,
    output logic                   Sftmd,
    output logic [1:0]             ALUOp,
    output logic                   RegWrite,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IORead,
    output logic                   IOWrite,
    output logic                   MemorIOtoReg,
    output logic                   illegal,
    output logic [2:0]             state_o
);

    state_t      r_state;
    state_t      w_next;
    ctrl_class_t r_cls;
    ctrl_class_t w_dec;
    ctrl_class_t w_cls;
    logic        w_legal;
    logic        r_io_sel;
    logic        w_hold;

    mc_ctrl_decode u_decode (
        .i_opcode (Opcode),
        .i_funct  (Function_opcode),
        .o_cls    (w_dec),
        .o_legal  (w_legal)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] r_mem_cnt;
    logic             w_tout;

    // Counter holds 0 on the first MEM cycle, so the limit-th MEM cycle
    // sees TIMEOUT_CYCLES-1.
    assign w_tout = (r_mem_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || (r_state != ST_MEM)) begin
            r_mem_cnt <= '0;
        end else begin
            r_mem_cnt <= r_mem_cnt + 1'b1;
        end
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_FETCH;
            r_cls    <= '0;
            r_io_sel <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_cls <= w_dec;
            end
            if ((r_state == ST_EXEC) && (r_cls.lw || r_cls.sw)) begin
                r_io_sel <= (Alu_resultHigh == IO_BASE_HIGH);
            end
        end
    end

    // During DECODE the class register is still being loaded, so the
    // selects come straight from the decoder for that one cycle.
    assign w_cls  = (r_state == ST_DECODE) ? w_dec : r_cls;
    assign w_hold = (r_state == ST_DECODE) || (r_state == ST_EXEC) ||
                    (r_state == ST_MEM)    || (r_state == ST_WB);

    assign Jr       = w_hold & w_cls.jr;
    assign Jmp      = w_hold & w_cls.j;
    assign Jal      = w_hold & w_cls.jal;
    assign Branch   = w_hold & w_cls.beq;
    assign nBranch  = w_hold & w_cls.bne;
    assign RegDST   = w_hold & w_cls.is_r;
    assign ALUSrc   = w_hold & (w_cls.is_i | w_cls.lw | w_cls.sw);
    assign I_format = w_hold & w_cls.is_i;
    assign Sftmd    = w_hold & w_cls.sftmd;
    assign ALUOp    = !w_hold                    ? ALUOP_MEM :
                      (w_cls.is_r | w_cls.is_i)  ? ALUOP_RI  :
                      (w_cls.beq | w_cls.bne)    ? ALUOP_BR  : ALUOP_MEM;
    assign state_o  = r_state;

    always_comb begin
        w_next       = r_state;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IORead       = 1'b0;
        IOWrite      = 1'b0;
        MemorIOtoReg = 1'b0;
        illegal      = 1'b0;
        unique case (r_state)
            ST_FETCH: begin
                // Reset parks the FSM in FETCH; keep IR untouched while held.
                IRWrite = !reset;
                w_next  = ST_DECODE;
            end
            ST_DECODE: begin
                if (!w_legal) begin
                    illegal = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = ST_FETCH;
                end else begin
                    w_next  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_cls.lw || r_cls.sw) begin
                    w_next = ST_MEM;
                end else if (r_cls.jal) begin
                    PCWrite  = 1'b1;
                    RegWrite = 1'b1;
                    w_next   = ST_FETCH;
                end else if (r_cls.beq || r_cls.bne || r_cls.j || r_cls.jr) begin
                    PCWrite = 1'b1;
                    w_next  = ST_FETCH;
                end else begin
                    w_next = ST_WB;
                end
            end
            ST_MEM: begin
                MemRead  = r_cls.lw & !r_io_sel;
                IORead   = r_cls.lw &  r_io_sel;
                MemWrite = r_cls.sw & !r_io_sel;
                IOWrite  = r_cls.sw &  r_io_sel;
                if (mem_ready) begin
                    if (r_cls.sw) begin
                        PCWrite = 1'b1;
                        w_next  = ST_FETCH;
                    end else begin
                        w_next  = ST_WB;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (w_tout) begin
                    w_next = ST_TOUT;
                end
`endif
            end
            ST_WB: begin
                RegWrite     = 1'b1;
                PCWrite      = 1'b1;
                MemorIOtoReg = r_cls.lw;
                w_next       = ST_FETCH;
            end
`ifdef MEM_TIMEOUT_EN
            ST_TOUT: begin
                illegal = 1'b1;
                PCWrite = 1'b1;
                w_next  = ST_FETCH;
            end
`endif
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

endmodule
